// File: rtl/fpmult_normalize_stage_pkg.sv
// ============================================================================
//  Module   : fpmult_normalize_stage_pkg
//  Purpose  : Shared constants and types for the FP multiplier normalization
//             stage: exponent bias, exception flag bit positions, skid-buffer
//             state encoding and the registered beat record.
//  Ports    : none (package)
//  Options  : FPMULT_NORM_EXC_EN -- enables the overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef MANTISSA
`define MANTISSA 23
`endif
`ifndef EXPONENT
`define EXPONENT 8
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

package fpmult_normalize_stage_pkg;

    localparam int c_EXP_BIAS = 127;
    localparam int c_EXC_W    = 5;
    localparam int c_OVF_BIT  = 2;
    localparam int c_UNF_BIT  = 1;

    // Skid buffer occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } bufState_t;

    // One normalized beat as held in the head or skid register.
    typedef struct packed {
        logic [`MANTISSA:0]  roundM;
        logic [`MANTISSA:0]  roundMP;
        logic [`EXPONENT:0]  roundE;
        logic [`EXPONENT:0]  roundEP;
        logic                grs;
        logic                sp;
        logic [c_EXC_W-1:0]  exc;
    } normBeat_t;

    // Places the overflow/underflow indications at their flag positions.
    function automatic logic [c_EXC_W-1:0] excFlags(input logic ovf, input logic unf);
        logic [c_EXC_W-1:0] flags;
        flags            = '0;
        flags[c_OVF_BIT] = ovf;
        flags[c_UNF_BIT] = unf;
        return flags;
    endfunction

endpackage : fpmult_normalize_stage_pkg

`default_nettype wire

// File: rtl/fpmult_normalize_stage_if.sv
// ============================================================================
//  Module   : fpmult_normalize_stage_if
//  Purpose  : Bundles the input beat, output beat and both valid/ready
//             handshakes of the normalization stage.
//  Ports    : none; modports
//               master - upstream/downstream environment view
//               slave  - normalization stage view
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fpmult_normalize_stage_if;
    import fpmult_normalize_stage_pkg::*;

    // Input side
    logic                         in_valid;
    logic                         in_ready;
    logic [2*(`MANTISSA+1)-1:0]   Prod;
    logic [`EXPONENT-1:0]         Ea;
    logic [`EXPONENT-1:0]         Eb;
    logic                         Sa;
    logic [c_EXC_W-1:0]           InExc;

    // Output side
    logic                         out_valid;
    logic                         out_ready;
    logic [`MANTISSA:0]           RoundM;
    logic [`MANTISSA:0]           RoundMP;
    logic [`EXPONENT:0]           RoundE;
    logic [`EXPONENT:0]           RoundEP;
    logic                         GRS;
    logic                         Sp;
    logic [c_EXC_W-1:0]           OutExc;

    modport master (
        output in_valid, Prod, Ea, Eb, Sa, InExc, out_ready,
        input  in_ready, out_valid, RoundM, RoundMP, RoundE, RoundEP, GRS, Sp, OutExc
    );

    modport slave (
        input  in_valid, Prod, Ea, Eb, Sa, InExc, out_ready,
        output in_ready, out_valid, RoundM, RoundMP, RoundE, RoundEP, GRS, Sp, OutExc
    );

endinterface : fpmult_normalize_stage_if

`default_nettype wire

// File: rtl/fpmult_normalize_stage_norm_core.sv
// ============================================================================
//  Module   : fpmult_norm_core
//  Purpose  : Combinational normalization of the 48-bit mantissa product:
//             selects the 23-bit fraction, forms the round-to-nearest-even
//             decision and the biased result exponent (plain and +1).
//  Ports    : i_prod      48-bit mantissa product (hidden bits included)
//             i_ea/i_eb   biased operand exponents
//             o_roundM    {0, fraction}, o_roundMP = o_roundM + 1
//             o_roundE    normalized exponent, o_roundEP = o_roundE + 1
//             o_grs       round-up decision
//             o_normExc   overflow/underflow flags (zero unless enabled)
//  Options  : FPMULT_NORM_EXC_EN -- computes overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpmult_norm_core
    import fpmult_normalize_stage_pkg::*;
#(
    parameter int EXP_BIAS = c_EXP_BIAS
) (
    input  wire logic [2*(`MANTISSA+1)-1:0] i_prod,
    input  wire logic [`EXPONENT-1:0]       i_ea,
    input  wire logic [`EXPONENT-1:0]       i_eb,
    output logic      [`MANTISSA:0]         o_roundM,
    output logic      [`MANTISSA:0]         o_roundMP,
    output logic      [`EXPONENT:0]         o_roundE,
    output logic      [`EXPONENT:0]         o_roundEP,
    output logic                            o_grs,
    output logic      [c_EXC_W-1:0]         o_normExc
);

    // The sign bit of the exponent is only needed to judge overflow and
    // underflow; without those flags the exponent is carried mod 2^9.
`ifdef FPMULT_NORM_EXC_EN
    localparam int c_E_W = `EXPONENT + 2;
`else
    localparam int c_E_W = `EXPONENT + 1;
`endif

    logic [`MANTISSA-1:0] w_frac;
    logic                 w_guard;
    logic                 w_sticky;
    logic [c_E_W-1:0]     w_eSum;
    logic [c_E_W-1:0]     w_e;

    always_comb begin
        w_eSum = c_E_W'(i_ea) + c_E_W'(i_eb) - c_E_W'(EXP_BIAS);
        if (i_prod[47]) begin
            // Product in [2,4): shift right by one and bump the exponent.
            w_frac   = i_prod[46:24];
            w_guard  = i_prod[23];
            w_sticky = |i_prod[22:0];
            w_e      = w_eSum + c_E_W'(1);
        end else begin
            w_frac   = i_prod[45:23];
            w_guard  = i_prod[22];
            w_sticky = |i_prod[21:0];
            w_e      = w_eSum;
        end
    end

    // Round up when above half, or exactly half with an odd fraction.
    assign o_grs     = w_guard & (w_sticky | w_frac[0]);
    assign o_roundM  = {1'b0, w_frac};
    assign o_roundMP = o_roundM + (`MANTISSA+1)'(1);
    assign o_roundE  = w_e[`EXPONENT:0];
    assign o_roundEP = w_e[`EXPONENT:0] + (`EXPONENT+1)'(1);

`ifdef FPMULT_NORM_EXC_EN
    logic w_ovf;
    logic w_unf;
    assign w_ovf     = $signed(w_e) >= $signed(c_E_W'(255));
    assign w_unf     = $signed(w_e) <= $signed(c_E_W'(0));
    assign o_normExc = excFlags(w_ovf, w_unf);
`else
    assign o_normExc = '0;
`endif

endmodule : fpmult_norm_core

`default_nettype wire

// File: rtl/fpmult_normalize_stage.sv
// ============================================================================
//  Module   : fpmult_normalize_stage
//  Purpose  : Registered normalization stage of the single-precision FP
//             multiplier. Normalizes each accepted beat and holds results in
//             a 2-entry skid buffer so downstream backpressure never drops
//             data. The rounding stage consumes the head entry directly.
//  Ports    : clk   clock
//             rst   synchronous active-high reset (discards buffered beats)
//             bus   fpmult_normalize_stage_if.slave
//                   in_valid/in_ready, Prod, Ea, Eb, Sa, InExc   (input beat)
//                   out_valid/out_ready, RoundM, RoundMP, RoundE, RoundEP,
//                   GRS, Sp, OutExc                               (head beat)
//  Options  : FPMULT_NORM_EXC_EN -- ORs overflow/underflow into OutExc.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpmult_normalize_stage
    import fpmult_normalize_stage_pkg::*;
#(
    parameter int EXP_BIAS = c_EXP_BIAS
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fpmult_normalize_stage_if.slave bus
);

    normBeat_t          w_newBeat;
    logic [c_EXC_W-1:0] w_normExc;

    bufState_t r_state;
    bufState_t w_stateNext;
    normBeat_t r_head;
    normBeat_t r_skid;

    logic w_accept;
    logic w_pop;
    logic w_loadHead;
    logic w_loadSkid;
    logic w_skidToHead;

    fpmult_norm_core #(
        .EXP_BIAS (EXP_BIAS)
    ) u_core (
        .i_prod    (bus.Prod),
        .i_ea      (bus.Ea),
        .i_eb      (bus.Eb),
        .o_roundM  (w_newBeat.roundM),
        .o_roundMP (w_newBeat.roundMP),
        .o_roundE  (w_newBeat.roundE),
        .o_roundEP (w_newBeat.roundEP),
        .o_grs     (w_newBeat.grs),
        .o_normExc (w_normExc)
    );

    assign w_newBeat.sp  = bus.Sa;
    assign w_newBeat.exc = bus.InExc | w_normExc;

    // Handshake
    assign bus.in_ready  = (r_state != ST_TWO);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign w_accept      = bus.in_valid  & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    // Next-state and register load selects
    always_comb begin
        w_stateNext  = r_state;
        w_loadHead   = 1'b0;
        w_loadSkid   = 1'b0;
        w_skidToHead = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_stateNext = ST_ONE;
                    w_loadHead  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    // Head leaves and is replaced by the incoming beat.
                    w_loadHead = 1'b1;
                end else if (w_accept) begin
                    w_stateNext = ST_TWO;
                    w_loadSkid  = 1'b1;
                end else if (w_pop) begin
                    w_stateNext = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_stateNext  = ST_ONE;
                    w_skidToHead = 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_loadHead) begin
                r_head <= w_newBeat;
            end else if (w_skidToHead) begin
                r_head <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= w_newBeat;
            end
        end
    end

    // The rounding stage sees the head entry.
    assign bus.RoundM  = r_head.roundM;
    assign bus.RoundMP = r_head.roundMP;
    assign bus.RoundE  = r_head.roundE;
    assign bus.RoundEP = r_head.roundEP;
    assign bus.GRS     = r_head.grs;
    assign bus.Sp      = r_head.sp;
    assign bus.OutExc  = r_head.exc;

endmodule : fpmult_normalize_stage

`default_nettype wire

// File: tb/tb_fpmult_normalize_stage.sv
// ============================================================================
//  Module   : tb_fpmult_normalize_stage
//  Purpose  : Self-checking bench for fpmult_normalize_stage: table of
//             directed normalization vectors with hand-computed results,
//             plus backpressure and mid-operation reset sequences.
//  Options  : FPMULT_NORM_EXC_EN -- expected OutExc includes ovf/unf.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpmult_normalize_stage;

`ifdef FPMULT_NORM_EXC_EN
    localparam bit c_EXC_EN = 1'b1;
`else
    localparam bit c_EXC_EN = 1'b0;
`endif
    localparam int c_NVEC = 17;

    typedef struct {
        logic [47:0] prod;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        sa;
        logic [4:0]  inExc;
        logic [23:0] m;
        logic [23:0] mp;
        logic [8:0]  e;
        logic [8:0]  ep;
        logic        grs;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   nTests = 0;
    int   nFail  = 0;
    vec_t vecs [c_NVEC];

    always #5 clk = ~clk;

    fpmult_normalize_stage_if nsIf ();

    fpmult_normalize_stage #(
        .EXP_BIAS (127)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (nsIf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] expExc(input vec_t v);
        logic [4:0] x;
        x = v.inExc;
        if (c_EXC_EN) begin
            x[2] = x[2] | v.ovf;
            x[1] = x[1] | v.unf;
        end
        return x;
    endfunction

    task automatic chkBeat(input string tag, input vec_t v);
        chk({tag, ".out_valid"}, 32'(nsIf.out_valid), 32'd1);
        chk({tag, ".RoundM"},    32'(nsIf.RoundM),    32'(v.m));
        chk({tag, ".RoundMP"},   32'(nsIf.RoundMP),   32'(v.mp));
        chk({tag, ".RoundE"},    32'(nsIf.RoundE),    32'(v.e));
        chk({tag, ".RoundEP"},   32'(nsIf.RoundEP),   32'(v.ep));
        chk({tag, ".GRS"},       32'(nsIf.GRS),       32'(v.grs));
        chk({tag, ".Sp"},        32'(nsIf.Sp),        32'(v.sa));
        chk({tag, ".OutExc"},    32'(nsIf.OutExc),    32'(expExc(v)));
    endtask

    task automatic chkZero(input string tag);
        chk({tag, ".out_valid"}, 32'(nsIf.out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(nsIf.in_ready),  32'd1);
        chk({tag, ".RoundM"},    32'(nsIf.RoundM),    32'd0);
        chk({tag, ".RoundMP"},   32'(nsIf.RoundMP),   32'd0);
        chk({tag, ".RoundE"},    32'(nsIf.RoundE),    32'd0);
        chk({tag, ".RoundEP"},   32'(nsIf.RoundEP),   32'd0);
        chk({tag, ".GRS"},       32'(nsIf.GRS),       32'd0);
        chk({tag, ".Sp"},        32'(nsIf.Sp),        32'd0);
        chk({tag, ".OutExc"},    32'(nsIf.OutExc),    32'd0);
    endtask

    task automatic drive(input vec_t v);
        nsIf.in_valid = 1'b1;
        nsIf.Prod     = v.prod;
        nsIf.Ea       = v.ea;
        nsIf.Eb       = v.eb;
        nsIf.Sa       = v.sa;
        nsIf.InExc    = v.inExc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [47:0] prod, input logic [7:0] ea, input logic [7:0] eb,
                                input logic sa, input logic [4:0] inExc,
                                input logic [23:0] m, input logic [23:0] mp,
                                input logic [8:0] e, input logic [8:0] ep,
                                input logic grs, input logic ovf, input logic unf);
        vec_t v;
        v.prod = prod; v.ea = ea; v.eb = eb; v.sa = sa; v.inExc = inExc;
        v.m = m; v.mp = mp; v.e = e; v.ep = ep; v.grs = grs; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        //              prod              ea    eb    sa  inExc     m          mp         e       ep      grs ovf unf
        vecs[0]  = mk(48'h900000000000, 127, 127, 0, 5'b00000, 24'h100000, 24'h100001, 9'h080, 9'h081, 0, 0, 0); // 1.5x1.5
        vecs[1]  = mk(48'h400000000000, 127, 127, 1, 5'b00000, 24'h000000, 24'h000001, 9'h07F, 9'h080, 0, 0, 0); // 1.0x1.0
        vecs[2]  = mk(48'h400000400000, 127, 127, 0, 5'b00000, 24'h000000, 24'h000001, 9'h07F, 9'h080, 0, 0, 0); // tie, even
        vecs[3]  = mk(48'h400000C00000, 127, 127, 1, 5'b01000, 24'h000001, 24'h000002, 9'h07F, 9'h080, 1, 0, 0); // tie, odd
        vecs[4]  = mk(48'h400000600000, 127, 127, 0, 5'b00000, 24'h000000, 24'h000001, 9'h07F, 9'h080, 1, 0, 0); // above half
        vecs[5]  = mk(48'hC00000800001, 130, 100, 1, 5'b00000, 24'h400000, 24'h400001, 9'h068, 9'h069, 1, 0, 0); // msb, sticky
        vecs[6]  = mk(48'h000000000000,   0,   0, 1, 5'b10001, 24'h000000, 24'h000001, 9'h181, 9'h182, 0, 0, 1); // zero
        vecs[7]  = mk(48'h400000000000, 254, 254, 0, 5'b00000, 24'h000000, 24'h000001, 9'h17D, 9'h17E, 0, 1, 0); // overflow
        vecs[8]  = mk(48'h400000000000,   1,   1, 0, 5'b00000, 24'h000000, 24'h000001, 9'h183, 9'h184, 0, 0, 1); // underflow
        vecs[9]  = mk(48'h400000000000, 126,   0, 0, 5'b00000, 24'h000000, 24'h000001, 9'h1FF, 9'h000, 0, 0, 1); // EP wraps
        vecs[10] = mk(48'h400000000000, 191, 191, 0, 5'b00000, 24'h000000, 24'h000001, 9'h0FF, 9'h100, 0, 1, 0); // E = 255
        vecs[11] = mk(48'h400000000000, 190, 191, 0, 5'b00000, 24'h000000, 24'h000001, 9'h0FE, 9'h0FF, 0, 0, 0); // E = 254
        vecs[12] = mk(48'h400000000000,  64,  64, 0, 5'b00000, 24'h000000, 24'h000001, 9'h001, 9'h002, 0, 0, 0); // E = 1
        vecs[13] = mk(48'h800000000000, 126,   0, 1, 5'b00000, 24'h000000, 24'h000001, 9'h000, 9'h001, 0, 0, 1); // E = 0
        vecs[14] = mk(48'hFFFFFF000000, 127, 127, 1, 5'b00010, 24'h7FFFFF, 24'h800000, 9'h080, 9'h081, 0, 0, 0); // MP carry
        vecs[15] = mk(48'h800001800000, 127, 127, 0, 5'b00000, 24'h000001, 24'h000002, 9'h080, 9'h081, 1, 0, 0); // msb tie odd
        vecs[16] = mk(48'h800000800000, 127, 127, 0, 5'b00000, 24'h000000, 24'h000001, 9'h080, 9'h081, 0, 0, 0); // msb tie even

        rst            = 1'b1;
        nsIf.in_valid  = 1'b0;
        nsIf.Prod      = '0;
        nsIf.Ea        = '0;
        nsIf.Eb        = '0;
        nsIf.Sa        = 1'b0;
        nsIf.InExc     = '0;
        nsIf.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chkZero("reset");

        // Table: one beat at a time, 1-cycle latency, then popped.
        nsIf.out_ready = 1'b1;
        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i]);
            chk($sformatf("v%0d.in_ready", i), 32'(nsIf.in_ready), 32'd1);
            tick();
            nsIf.in_valid = 1'b0;
            chkBeat($sformatf("v%0d", i), vecs[i]);
            tick();
            chk($sformatf("v%0d.drained", i), 32'(nsIf.out_valid), 32'd0);
        end

        // Backpressure: A, B buffered, C stalled, then drained in order.
        nsIf.out_ready = 1'b0;
        drive(vecs[0]);
        tick();
        chkBeat("bpA.head", vecs[0]);
        drive(vecs[5]);
        chk("bpB.in_ready", 32'(nsIf.in_ready), 32'd1);
        tick();
        drive(vecs[14]);
        chk("bpC.in_ready", 32'(nsIf.in_ready), 32'd0);
        tick();
        chk("bpC.in_ready_hold", 32'(nsIf.in_ready), 32'd0);
        chkBeat("bpA.hold", vecs[0]);
        nsIf.out_ready = 1'b1;
        tick();
        chkBeat("bpB", vecs[5]);
        chk("bpB.in_ready", 32'(nsIf.in_ready), 32'd1);
        tick();
        nsIf.in_valid = 1'b0;
        chkBeat("bpC", vecs[14]);
        tick();
        chk("bp.drained", 32'(nsIf.out_valid), 32'd0);

        // Reset while holding two beats.
        nsIf.out_ready = 1'b0;
        drive(vecs[3]);
        tick();
        drive(vecs[4]);
        tick();
        nsIf.in_valid = 1'b0;
        chk("rst.full", 32'(nsIf.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chkZero("midrst");
        nsIf.out_ready = 1'b1;
        drive(vecs[7]);
        tick();
        nsIf.in_valid = 1'b0;
        chkBeat("postrst", vecs[7]);
        tick();
        chk("postrst.drained", 32'(nsIf.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_fpmult_normalize_stage

`default_nettype wire

// File: doc/fpmult_normalize_stage.md
Name: fpmult_normalize_stage

Overview:
- Registered normalization stage of the single-precision FP multiplier, directly upstream of the rounding stage.
- Takes the raw 48-bit mantissa product, both biased operand exponents, product sign and input exception flags.
- Produces the normalized mantissa/exponent pairs (plain and +1), the round-up decision GRS, sign and flags, which the rounding stage consumes combinationally.
- Valid/ready handshake with a 2-entry skid buffer so backpressure never drops data.

Parameters:
- EXP_BIAS, 127, exponent bias subtracted from Ea+Eb.
- Widths come from the existing `MANTISSA (23), `EXPONENT (8) and `DWIDTH (32) macros; no width parameters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- Prod  in  2*(`MANTISSA+1)=48  unsigned product of the two 24-bit mantissas (hidden bits included)
- Ea, Eb  in  `EXPONENT=8 each  biased operand exponents
- Sa  in  1  product sign, already XORed upstream
- InExc  in  5  exception flags from the input checker
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- RoundM  out  `MANTISSA+1=24  {1'b0, fraction[22:0]}
- RoundMP  out  24  RoundM + 1
- RoundE  out  `EXPONENT+1=9  normalized exponent
- RoundEP  out  9  RoundE + 1, mod 2^9
- GRS  out  1  round-up decision
- Sp  out  1  registered sign
- OutExc  out  5  registered flags

Behaviour:
- Normalize, combinational on the input beat:
  - Esum = Ea + Eb - EXP_BIAS, computed in 10-bit signed.
  - If Prod[47]: frac = Prod[46:24], G = Prod[23], S = |Prod[22:0], E = Esum + 1.
  - Else: frac = Prod[45:23], G = Prod[22], S = |Prod[21:0], E = Esum.
  - GRS = G & (S | frac[0]) (round to nearest, ties to even).
  - RoundM = {0, frac}; RoundMP = RoundM + 1 (carry into bit 23 is the rounding stage's concern).
  - RoundE = E[8:0]; RoundEP = E[8:0] + 1, wrapping mod 512.
  - Sp = Sa.
- The computed results are stored in registers; the ports show the head entry.
- Buffer FSM, states EMPTY, ONE, TWO:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - Accept when in_valid & in_ready. Pop when out_valid & out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE, head reloads with the new beat.
  - TWO: pop -> ONE, skid entry moves to head; no accept, since in_ready = 0.
- Order is strictly FIFO. Latency is 1 cycle from accept to out_valid when the stage is empty.
- Output data holds stable while out_valid & !out_ready.
- Reset, including mid-operation: state = EMPTY, out_valid = 0, all data outputs and skid registers = 0, in_ready = 1 in the cycle after rst deasserts. In-flight beats are discarded.
- Prod = 0 (zero operand) gives frac = 0 and GRS = 0; zero/NaN handling is carried by InExc.

Optional Feature:
- FPMULT_NORM_EXC_EN defined:
  - OutExc = InExc | {2'b00, ovf, unf, 1'b0}.
  - ovf = (E >= 255 signed); unf = (E <= 0 signed).
  - Both are evaluated on the 10-bit E and captured with the beat.
- Not defined: OutExc = InExc and no extra logic.

Decomposition:
- Shared package (or the existing FPMult defines include) holds EXP_BIAS, the flag bit positions OVF_BIT = 2 and UNF_BIT = 1, and the FSM state encoding.
- One sub-module, fpmult_norm_core: purely combinational normalize/GRS/exponent logic.
- The top level is the skid FSM plus the registers.

Test Plan:
- 1.5x1.5: Prod = 0x900000000000, Ea = Eb = 127 -> RoundM = 0x100000, RoundMP = 0x100001, RoundE = 0x080, RoundEP = 0x081, GRS = 0; rounding stage gives Z = 0x40100000.
- 1.0x1.0: Prod = 0x400000000000, Ea = Eb = 127 -> RoundM = 0, RoundE = 0x07F, GRS = 0, 1-cycle latency.
- Ties:
  - Prod = 0x400000400000 -> GRS = 0 (even).
  - Prod = 0x400000C00000 -> frac = 1, GRS = 1.
- Backpressure: out_ready = 0 while beats A, B, C are offered back to back -> A and B accepted, in_ready = 0 on C. Then out_ready = 1 -> outputs A, B, C in order, none lost or duplicated.
- Reset: assert rst with the stage in TWO -> next cycle out_valid = 0, state EMPTY, outputs 0; a new beat after reset is emitted correctly.
- FPMULT_NORM_EXC_EN:
  - Ea = Eb = 254, Prod = 0x400000000000 -> OutExc[2] = 1.
  - Ea = Eb = 1 -> OutExc[1] = 1.
  - Without the macro, OutExc = InExc.
